// File: rtl/regfile_wr_pkg.sv
// Constants and types shared by the register-file write arbiter and its users.
package regfile_wr_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_CSR = 2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_wr_arb_rr_arbiter.sv
// Round-robin arbiter: the search begins at rr_ptr and the pointer moves just
// past each winner once that winner is actually granted.
module rr_arbiter
    import regfile_wr_pkg::*;
#(
    parameter int N = 3,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic [N-1:0]     req,
    input  logic             enable,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] rr_ptr;
    logic             found;
    int               k;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(rr_ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!found && req[IDX_W'(k)]) begin
                found = 1'b1;
                index = IDX_W'(k);
            end
        end
        if (found && enable) begin
            grant[index] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            rr_ptr <= '0;
        end else if (|grant) begin
            rr_ptr <= (index == IDX_W'(N - 1)) ? '0 : index + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wr_arb.sv
// Shares the register-file write port between ALU, LSU and CSR writeback through
// one registered write stage, with a forwarding view of the pending entry.
module regfile_wr_arb
    import regfile_wr_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk_i,
    input  logic                      nrst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    input  logic                      stall_i,
    input  logic                      flush_i,
    output logic                      rf_we_o,
    output logic [ADDR_W-1:0]         rf_waddr_o,
    output logic [DATA_W-1:0]         rf_wdata_o,
    output logic [IDX_W-1:0]          grant_id_o,
    input  logic [ADDR_W-1:0]         fwd_addr_i,
    output logic                      fwd_hit_o,
    output logic [DATA_W-1:0]         fwd_data_o
);

    logic                vld_p1;
    logic [ADDR_W-1:0]   addr_p1;
    logic [DATA_W-1:0]   data_p1;
    logic [IDX_W-1:0]    id_p1;

    logic                accept;
    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    win_idx;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                load;

    // Holding reset low keeps every grant off, so nothing is consumed during reset.
    assign accept = nrst_i & ~flush_i & (~vld_p1 | ~stall_i);

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .req    (req_valid_i),
        .enable (accept),
        .grant  (grant),
        .index  (win_idx)
    );

    assign req_ready_o = grant;
    assign win_addr    = req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
    assign win_data    = req_data_i[int'(win_idx)*DATA_W +: DATA_W];
    // x0 writes are consumed here but never occupy the stage.
    assign load        = (|grant) & (win_addr != '0);

    // ---- stage p1: the single pending register-file write ----
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
            id_p1   <= IDX_W'(REQ_ALU);
        end else if (flush_i) begin
            vld_p1  <= 1'b0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            addr_p1 <= win_addr;
            data_p1 <= win_data;
            id_p1   <= win_idx;
        end else if (vld_p1 && !stall_i) begin
            vld_p1  <= 1'b0;
        end
    end

    assign rf_we_o    = vld_p1 & ~stall_i & ~flush_i & nrst_i;
    assign rf_waddr_o = addr_p1;
    assign rf_wdata_o = data_p1;
    assign grant_id_o = id_p1;

    assign fwd_hit_o  = vld_p1 & (fwd_addr_i == addr_p1) & (fwd_addr_i != '0);
    assign fwd_data_o = fwd_hit_o ? data_p1 : '0;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Bench for regfile_wr_arb: a reference model predicts grants and stage
// contents, and each scenario task compares the DUT against it.
module tb_regfile_wr_arb;
    import regfile_wr_pkg::*;

    localparam int N = 3;

    typedef struct packed {
        wr_req_t    req;
        logic [1:0] id;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  nrst;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N*ADDR_W-1:0]   req_addr;
    logic [N*DATA_W-1:0]   req_data;
    logic                  stall;
    logic                  flush;
    logic                  rf_we;
    logic [ADDR_W-1:0]     rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic [1:0]            grant_id;
    logic [ADDR_W-1:0]     fwd_addr;
    logic                  fwd_hit;
    logic [DATA_W-1:0]     fwd_data;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t       sb[$];
    logic [1:0] m_ptr;
    logic       m_vld;

    always #5 clk = ~clk;

    regfile_wr_arb #(.NUM_REQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i       (clk),
        .nrst_i      (nrst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .stall_i     (stall),
        .flush_i     (flush),
        .rf_we_o     (rf_we),
        .rf_waddr_o  (rf_waddr),
        .rf_wdata_o  (rf_wdata),
        .grant_id_o  (grant_id),
        .fwd_addr_i  (fwd_addr),
        .fwd_hit_o   (fwd_hit),
        .fwd_data_o  (fwd_data)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [N-1:0] m_grant();
        logic [N-1:0] g;
        int           k;
        g = '0;
        if (nrst && !flush && (!m_vld || !stall)) begin
            for (int i = 0; i < N; i++) begin
                k = (int'(m_ptr) + i) % N;
                if (g == '0 && req_valid[k[1:0]]) g[k[1:0]] = 1'b1;
            end
        end
        return g;
    endfunction

    // Advance the model across one clock edge, then return at the next negedge.
    task automatic tick();
        logic [N-1:0]      g;
        logic [ADDR_W-1:0] a;
        exp_t              e;
        g = m_grant();
        if (!nrst) begin
            m_ptr = '0;
            m_vld = 1'b0;
            sb.delete();
        end else if (flush) begin
            m_vld = 1'b0;
            sb.delete();
        end else begin
            if (m_vld && !stall) begin
                m_vld = 1'b0;
                void'(sb.pop_front());
            end
            for (int k = 0; k < N; k++) begin
                if (g[k]) begin
                    m_ptr = 2'((k + 1) % N);
                    a = req_addr[k*ADDR_W +: ADDR_W];
                    if (a != '0) begin
                        e.req.addr = a;
                        e.req.data = req_data[k*DATA_W +: DATA_W];
                        e.id       = 2'(k);
                        sb.push_back(e);
                        m_vld = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int k, input logic v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        req_valid[k]               = v;
        req_addr[k*ADDR_W +: ADDR_W] = a;
        req_data[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        nrst = 1'b0; req_valid = '0; stall = 1'b0; flush = 1'b0; fwd_addr = '0;
        tick();
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        nrst = 1'b0; stall = 1'b0; flush = 1'b0; fwd_addr = '0;
        req_addr = '0; req_data = '0; req_valid = '1;
        set_req(REQ_ALU, 1'b1, 5'd1, 32'h1);
        #1;
        n_checks++; if (req_ready !== 3'b000) $display("FAIL reset_ready got %b want 000", req_ready); else n_pass++;
        tick();
        n_checks++; if (rf_we !== 1'b0) $display("FAIL reset_we got %b want 0", rf_we); else n_pass++;
        n_checks++; if (rf_waddr !== 5'd0) $display("FAIL reset_waddr got %0d want 0", rf_waddr); else n_pass++;
        n_checks++; if (rf_wdata !== 32'd0) $display("FAIL reset_wdata got %h want 0", rf_wdata); else n_pass++;
        n_checks++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id got %0d want 0", grant_id); else n_pass++;
        req_valid = '0;
        nrst = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        set_req(REQ_ALU, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        n_checks++; if (req_ready !== 3'b001) $display("FAIL single_ready got %b want 001", req_ready); else n_pass++;
        tick();
        req_valid = '0;
        #1;
        n_checks++; if (rf_we !== 1'b1) $display("FAIL single_we got %b want 1", rf_we); else n_pass++;
        n_checks++; if (rf_waddr !== 5'd5) $display("FAIL single_waddr got %0d want 5", rf_waddr); else n_pass++;
        n_checks++; if (rf_wdata !== 32'hDEADBEEF) $display("FAIL single_wdata got %h want deadbeef", rf_wdata); else n_pass++;
        n_checks++; if (grant_id !== 2'd0) $display("FAIL single_grant_id got %0d want 0", grant_id); else n_pass++;
        tick();
    endtask

    task automatic test_fairness();
        logic [N-1:0] want;
        logic [39:0]  got_w, exp_w;
        do_reset();
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 5'(k + 1), 32'h100 + k);
        for (int c = 0; c < 6; c++) begin
            #1;
            want = 3'b001 << (c % 3);
            n_checks++; if (req_ready !== want) $display("FAIL fair_ready[%0d] got %b want %b", c, req_ready, want); else n_pass++;
            got_w = {rf_we, rf_waddr, rf_wdata, grant_id};
            if (c == 0) exp_w = '0;
            else exp_w = {1'b1, sb[0].req.addr, sb[0].req.data, sb[0].id};
            n_checks++;
            if (c == 0 ? (rf_we !== 1'b0) : (got_w !== exp_w || rf_waddr !== 5'((c - 1) % 3 + 1)))
                $display("FAIL fair_write[%0d] got %h want %h", c, got_w, exp_w);
            else n_pass++;
            tick();
        end
        req_valid = '0;
        #1;
        n_checks++; if ({rf_we, rf_waddr, grant_id} !== {1'b1, 5'd3, 2'd2})
            $display("FAIL fair_last_write got %b/%0d/%0d want 1/3/2", rf_we, rf_waddr, grant_id); else n_pass++;
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        set_req(REQ_ALU, 1'b1, 5'd7, 32'h77);
        #1;
        tick();
        req_valid = '0;
        stall = 1'b1;
        set_req(REQ_LSU, 1'b1, 5'd8, 32'h88);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (rf_we !== 1'b0) $display("FAIL stall_we[%0d] got %b want 0", c, rf_we); else n_pass++;
            n_checks++; if (req_ready !== 3'b000) $display("FAIL stall_ready[%0d] got %b want 000", c, req_ready); else n_pass++;
            tick();
        end
        stall = 1'b0;
        #1;
        n_checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h77})
            $display("FAIL stall_release_write got %b/%0d/%h want 1/7/77", rf_we, rf_waddr, rf_wdata); else n_pass++;
        n_checks++; if (req_ready !== 3'b010) $display("FAIL stall_release_ready got %b want 010", req_ready); else n_pass++;
        tick();
        req_valid = '0;
        #1;
        n_checks++; if ({rf_we, rf_waddr, rf_wdata, grant_id} !== {1'b1, 5'd8, 32'h88, 2'd1})
            $display("FAIL stall_lsu_write got %b/%0d/%h/%0d want 1/8/88/1", rf_we, rf_waddr, rf_wdata, grant_id); else n_pass++;
        tick();
        stall = 1'b1;
        set_req(REQ_ALU, 1'b1, 5'd10, 32'hA);
        #1;
        n_checks++; if (req_ready !== 3'b001) $display("FAIL stall_empty_ready got %b want 001", req_ready); else n_pass++;
        tick();
        req_valid = '0;
        set_req(REQ_LSU, 1'b1, 5'd12, 32'hC);
        #1;
        n_checks++; if ({req_ready, rf_we} !== 4'b0000)
            $display("FAIL stall_full_block got ready=%b we=%b want 000/0", req_ready, rf_we); else n_pass++;
        stall = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_x0();
        do_reset();
        set_req(REQ_LSU, 1'b1, 5'd3, 32'h33);
        #1;
        n_checks++; if (req_ready !== 3'b010) $display("FAIL x0_lsu_ready got %b want 010", req_ready); else n_pass++;
        tick();
        req_valid = '0;
        set_req(REQ_CSR, 1'b1, 5'd0, 32'h1234);
        #1;
        n_checks++; if (req_ready !== 3'b100) $display("FAIL x0_csr_ready got %b want 100", req_ready); else n_pass++;
        tick();
        req_valid = '0;
        #1;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL x0_no_write got %b want 0", rf_we); else n_pass++;
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 5'(k + 1), 32'h200 + k);
        #1;
        n_checks++; if (req_ready !== 3'b001) $display("FAIL x0_ptr_advanced got %b want 001", req_ready); else n_pass++;
        req_valid = '0;
    endtask

    task automatic test_flush();
        do_reset();
        set_req(REQ_ALU, 1'b1, 5'd9, 32'h99);
        #1;
        tick();
        set_req(REQ_ALU, 1'b1, 5'd11, 32'hB);
        flush = 1'b1;
        #1;
        n_checks++; if (req_ready !== 3'b000) $display("FAIL flush_ready got %b want 000", req_ready); else n_pass++;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL flush_we got %b want 0", rf_we); else n_pass++;
        tick();
        flush = 1'b0;
        #1;
        n_checks++; if (req_ready !== 3'b001) $display("FAIL flush_after_ready got %b want 001", req_ready); else n_pass++;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL flush_dropped got %b want 0", rf_we); else n_pass++;
        tick();
        req_valid = '0;
        #1;
        n_checks++; if ({rf_we, rf_waddr, rf_wdata, grant_id} !== {1'b1, 5'd11, 32'hB, 2'd0})
            $display("FAIL flush_next_write got %b/%0d/%h/%0d want 1/11/b/0", rf_we, rf_waddr, rf_wdata, grant_id); else n_pass++;
        tick();
    endtask

    task automatic test_fwd_reset();
        do_reset();
        set_req(REQ_ALU, 1'b1, 5'd4, 32'h55);
        #1;
        tick();
        req_valid = '0;
        fwd_addr = 5'd4;
        #1;
        n_checks++; if ({fwd_hit, fwd_data} !== {1'b1, 32'h55})
            $display("FAIL fwd_hit got %b/%h want 1/55", fwd_hit, fwd_data); else n_pass++;
        fwd_addr = 5'd5;
        #1;
        n_checks++; if ({fwd_hit, fwd_data} !== {1'b0, 32'h0})
            $display("FAIL fwd_miss got %b/%h want 0/0", fwd_hit, fwd_data); else n_pass++;
        fwd_addr = 5'd0;
        nrst = 1'b0;
        #1;
        n_checks++; if (fwd_hit !== 1'b0) $display("FAIL fwd_x0 got %b want 0", fwd_hit); else n_pass++;
        n_checks++; if (rf_we !== 1'b0) $display("FAIL reset_cycle_we got %b want 0", rf_we); else n_pass++;
        tick();
        nrst = 1'b1;
        fwd_addr = 5'd4;
        #1;
        n_checks++; if ({rf_we, fwd_hit, rf_waddr} !== {1'b0, 1'b0, 5'd0})
            $display("FAIL reset_cleared got we=%b hit=%b waddr=%0d want 0/0/0", rf_we, fwd_hit, rf_waddr); else n_pass++;
    endtask

    initial begin
        m_ptr = '0;
        m_vld = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_stall();
        test_x0();
        test_flush();
        test_fwd_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arb.md
Name: regfile_wr_arb

Overview:
- Shares the single register-file write port between several writeback sources (ALU, load unit, CSR unit) using round-robin arbitration.
- Holds one registered write stage in front of the port; the stage's valid bit and payload are plain enable-gated registers.
- Provides a forwarding query into the stage so readers see a write that is pending but not yet committed.
- Sits between the writeback sources and the register file in the core.

Parameters:
- NUM_REQ, 3, number of write requesters; index 0 is ALU, 1 is LSU, 2 is CSR.
- ADDR_W, 5, register address width.
- DATA_W, 32, write data width.

Ports:
- clk_i  in  1  clock
- nrst_i  in  1  reset; synchronous, active-low
- req_valid_i  in  NUM_REQ  per-requester write request
- req_ready_o  out  NUM_REQ  per-requester grant (one-hot or zero)
- req_addr_i  in  NUM_REQ*ADDR_W  packed destination addresses; requester k occupies slice k
- req_data_i  in  NUM_REQ*DATA_W  packed write data; requester k occupies slice k
- stall_i  in  1  register-file port blocked; stage must hold its contents
- flush_i  in  1  discard the pending stage entry
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  ADDR_W  write address
- rf_wdata_o  out  DATA_W  write data
- grant_id_o  out  clog2(NUM_REQ)  requester index held in the stage
- fwd_addr_i  in  ADDR_W  forwarding query address
- fwd_hit_o  out  1  stage is valid with a matching nonzero address
- fwd_data_o  out  DATA_W  stage data; zero when fwd_hit_o is 0

Behaviour:
- Reset (nrst_i=0 sampled at a clock edge):
  - stage_valid=0, rr_ptr=0.
  - rf_waddr_o, rf_wdata_o and grant_id_o are 0; rf_we_o=0.
  - req_ready_o is all-zero while nrst_i=0.
- Handshake:
  - A requester holds valid, addr and data stable until it sees valid&ready in the same cycle.
  - A transfer occurs when valid&ready are both high.
  - At most one req_ready_o bit is high per cycle.
- Accept condition: accept = ~flush_i & (~stage_valid | ~stall_i). The stage is empty or drains this cycle, so the one-entry stage never overflows.
- Arbitration (combinational):
  - Search starts at rr_ptr and proceeds upward modulo NUM_REQ; the first valid requester wins.
  - ready goes to the winner only when accept=1.
  - On a transfer, rr_ptr becomes (winner+1) mod NUM_REQ. Otherwise rr_ptr is unchanged.
- x0 writes: a request with addr=0 is granted and consumed but never loaded into the stage. stage_valid is not set by it, and rr_ptr still advances.
- Stage update, in priority order:
  1. flush_i=1: stage_valid becomes 0.
  2. Transfer with nonzero addr: load addr, data and winner id; stage_valid becomes 1.
  3. Stage draining with no new load: stage_valid becomes 0.
  4. Otherwise: hold.
- Write port:
  - rf_we_o = stage_valid & ~stall_i & ~flush_i.
  - Latency is one cycle from the accept edge to rf_we_o, with a continuous rate of one write per cycle.
- Stall: with stall_i=1 and stage_valid=1, all ready signals are 0 and the stage holds. With stall_i=1 and the stage empty, one new entry is accepted, after which acceptance stops.
- Flush: flush_i and a same-cycle request yield no grant. The pending entry is dropped and rf_we_o=0 in that cycle.
- Forwarding (combinational from stage registers):
  - fwd_hit_o = stage_valid & (fwd_addr_i == stage_addr) & (fwd_addr_i != 0).
  - fwd_data_o = stage_data when hit, else 0.
- Reset mid-operation: a pending stage entry is lost and no write is issued in the reset cycle.

Decomposition:
- Package regfile_wr_pkg holds:
  - ADDR_W and DATA_W constants;
  - requester index constants REQ_ALU=0, REQ_LSU=1, REQ_CSR=2;
  - typedef wr_req_t {addr, data}.
- Sub-module rr_arbiter (parameter N):
  - inputs: req vector, enable, clk_i, nrst_i;
  - outputs: one-hot grant and index;
  - owns rr_ptr.
- The top-level module keeps the stage, x0 filtering, flush/stall logic and forwarding.

Test Plan:
- Single write: after reset, ALU valid with addr=5, data=0xDEADBEEF → ready[0]=1 that cycle; next cycle rf_we_o=1, waddr=5, wdata=0xDEADBEEF, grant_id=0.
- Fairness: all three valid continuously for 6 cycles with addrs 1, 2, 3 → grant order 0,1,2,0,1,2; exactly one rf write per cycle.
- Stall: stage holds addr=7, then stall_i=1 for 3 cycles with LSU valid → rf_we_o=0 and ready=0 throughout; on release, the addr=7 write issues and LSU is granted that same cycle.
- x0 drop: CSR valid with addr=0, data=0x1234 → ready[2]=1; next cycle rf_we_o=0, and rr_ptr has advanced to 0.
- Flush: stage holds addr=9, flush_i=1 with ALU valid → no grant and no write that cycle; the following cycle ALU is granted.
- Forwarding/reset: stage holds addr=4, data=0x55 → fwd_addr=4 gives hit=1, data 0x55; fwd_addr=0 gives hit=0. nrst_i=0 for one edge → stage cleared, no write issued.
